// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types, byte-enable constants and helpers for the data-memory access path.
//   state_t       : access sequencer states
//   size_t        : access width (byte, halfword, word)
//   BE_*          : byte-enable patterns
//   to_size       : decode byte/halfword flags into an access width
//   is_misaligned : alignment check for a width and byte offset
package mips_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    function automatic size_t to_size(input logic is_b, input logic is_h);
        return is_b ? SZ_B : is_h ? SZ_H : SZ_W;
    endfunction

    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        return sz == SZ_H ? off[0] : sz == SZ_W ? (off != 2'b00) : 1'b0;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane handling for data-memory accesses.
//   size      in   access width
//   off       in   byte offset within the word
//   uns       in   zero-extend loads
//   wdata     in   right-justified store data
//   rdata     in   raw word read from memory
//   be        out  byte enables
//   wdata_rep out  store data replicated across lanes
//   rdata_ext out  load data shifted down and extended
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted   = rdata >> {off, 3'b000};
    assign be        = size == SZ_B ? BE_B0 << off : size == SZ_H ? (off[1] ? BE_H_HI : BE_H_LO) : BE_W;
    assign wdata_rep = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    assign rdata_ext = size == SZ_B ? {{24{~uns & shifted[7]}}, shifted[7:0]} :
                       size == SZ_H ? {{16{~uns & shifted[15]}}, shifted[15:0]} : rdata;

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto a req/gnt/rvalid data memory.
//   clk, rst_n                      clock, async active-low reset
//   ReqValidM, MemWriteM, IsLbSbM,
//   IsLhShM, LoadUnsM, AddrM,
//   WriteDataM                      MEM-stage access request
//   StallM, DoneM, LoadDataM,
//   AdelM, AdesM, BusErrM           pipeline status and load result
//   MemReq, MemWe, MemAddr, MemBE,
//   MemWData                        memory request port
//   MemGnt, MemRValid, MemRData     memory response port
module dmem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValidM,
    input  logic        MemWriteM,
    input  logic        IsLbSbM,
    input  logic        IsLhShM,
    input  logic        LoadUnsM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic        DoneM,
    output logic [31:0] LoadDataM,
    output logic        AdelM,
    output logic        AdesM,
    output logic        BusErrM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWData,
    input  logic        MemGnt,
    input  logic        MemRValid,
    input  logic [31:0] MemRData
);

    localparam int CW = $clog2(TIMEOUT_CYC);
    // Counter value in the last REQ/RESP cycle before the bus is declared dead.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 2);

    state_t        state, next_state;
    size_t         size_in, size_q, size_sel;
    logic          we_q, uns_q, misal, start, timeout, in_req, in_resp;
    logic [1:0]    off_q;
    logic [31:0]   addr_q, wdata_q, rdata_q, wdata_rep, rdata_ext;
    logic [3:0]    be_q, be;
    logic [CW-1:0] cnt;
    logic          buserr_q;

    assign size_in  = to_size(IsLbSbM, IsLhShM);
    assign misal    = is_misaligned(size_in, AddrM[1:0]);
    assign start    = state == IDLE && ReqValidM && !misal;
    assign in_req   = state == REQ;
    assign in_resp  = state == RESP;
    assign timeout  = cnt >= TO_LAST;
    // The aligner serves the incoming request in IDLE and the latched access afterwards.
    assign size_sel = state == IDLE ? size_in : size_q;

    mem_lane_align u_align (
        .size      (size_sel),
        .off       (state == IDLE ? AddrM[1:0] : off_q),
        .uns       (state == IDLE ? LoadUnsM : uns_q),
        .wdata     (WriteDataM),
        .rdata     (MemRData),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_B;
            uns_q    <= 1'b0;
            off_q    <= 2'b00;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            buserr_q <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                we_q     <= MemWriteM;
                size_q   <= size_in;
                uns_q    <= LoadUnsM;
                off_q    <= AddrM[1:0];
                addr_q   <= {AddrM[31:2], 2'b00};
                be_q     <= be;
                wdata_q  <= wdata_rep;
                rdata_q  <= '0;
                buserr_q <= 1'b0;
                cnt      <= '0;
            end
            if (in_req || in_resp)
                cnt <= cnt + 1'b1;
            if (in_resp && MemRValid)
                rdata_q <= rdata_ext;
            // A completion in the timeout cycle takes priority over the bus error.
            if (timeout && ((in_req && !MemGnt) || (in_resp && !MemRValid))) begin
                buserr_q <= 1'b1;
                rdata_q  <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? REQ : IDLE;
            REQ:     next_state = MemGnt ? (we_q ? DONE : RESP) : timeout ? DONE : REQ;
            RESP:    next_state = (MemRValid || timeout) ? DONE : RESP;
            default: next_state = IDLE;
        endcase
    end

    assign StallM    = start || in_req || in_resp;
    assign DoneM     = state == DONE;
    assign LoadDataM = DoneM ? rdata_q : '0;
    assign BusErrM   = DoneM & buserr_q;
    assign AdelM     = state == IDLE && ReqValidM && misal && !MemWriteM;
    assign AdesM     = state == IDLE && ReqValidM && misal && MemWriteM;
    assign MemReq    = in_req;
    assign MemWe     = in_req & we_q;
    assign MemAddr   = in_req ? addr_q : '0;
    assign MemBE     = in_req ? be_q : '0;
    assign MemWData  = in_req ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed self-checking bench for dmem_access_ctrl (TIMEOUT_CYC=8).
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ReqValidM = 1'b0, MemWriteM = 1'b0, IsLbSbM = 1'b0, IsLhShM = 1'b0, LoadUnsM = 1'b0;
    logic [31:0] AddrM = '0, WriteDataM = '0;
    logic        StallM, DoneM, AdelM, AdesM, BusErrM;
    logic [31:0] LoadDataM;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBE;
    logic        MemGnt = 1'b0, MemRValid = 1'b0;
    logic [31:0] MemRData = '0;

    int checks = 0;
    int failures = 0;

    dmem_access_ctrl #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .ReqValidM(ReqValidM), .MemWriteM(MemWriteM),
        .IsLbSbM(IsLbSbM), .IsLhShM(IsLhShM), .LoadUnsM(LoadUnsM), .AddrM(AddrM),
        .WriteDataM(WriteDataM), .StallM(StallM), .DoneM(DoneM), .LoadDataM(LoadDataM),
        .AdelM(AdelM), .AdesM(AdesM), .BusErrM(BusErrM), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemBE(MemBE), .MemWData(MemWData), .MemGnt(MemGnt),
        .MemRValid(MemRValid), .MemRData(MemRData)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic b, input logic h, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        ReqValidM = 1'b1; MemWriteM = we; IsLbSbM = b; IsLhShM = h; LoadUnsM = uns;
        AddrM = addr; WriteDataM = wd;
    endtask

    // Full access with gnt in the first REQ cycle and rvalid in the first RESP cycle.
    task automatic run_access(input string name, input logic we, input logic b, input logic h,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input logic [31:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_ld);
        set_req(we, b, h, uns, addr, wd);
        #1;
        checks++;
        if (StallM !== 1'b1 || MemReq !== 1'b0) begin
            failures++;
            $display("FAIL %s idle: StallM=%b MemReq=%b want 1 0", name, StallM, MemReq);
        end
        cyc; MemGnt = 1'b1; #1;
        checks++;
        if (MemReq !== 1'b1 || MemWe !== we || StallM !== 1'b1) begin
            failures++;
            $display("FAIL %s req: MemReq=%b MemWe=%b StallM=%b want 1 %b 1", name, MemReq, MemWe, StallM, we);
        end
        checks++;
        if (MemAddr !== exp_addr || MemBE !== exp_be) begin
            failures++;
            $display("FAIL %s addr/be: got %h/%b want %h/%b", name, MemAddr, MemBE, exp_addr, exp_be);
        end
        if (we) begin
            checks++;
            if (MemWData !== exp_wd) begin
                failures++;
                $display("FAIL %s wdata: got %h want %h", name, MemWData, exp_wd);
            end
        end
        cyc; MemGnt = 1'b0;
        if (!we) begin
            MemRValid = 1'b1; MemRData = rd; #1;
            checks++;
            if (StallM !== 1'b1 || MemReq !== 1'b0 || DoneM !== 1'b0) begin
                failures++;
                $display("FAIL %s resp: StallM=%b MemReq=%b DoneM=%b want 1 0 0", name, StallM, MemReq, DoneM);
            end
            cyc; MemRValid = 1'b0; MemRData = '0;
        end
        #1;
        checks++;
        if (DoneM !== 1'b1 || StallM !== 1'b0 || BusErrM !== 1'b0 || MemReq !== 1'b0) begin
            failures++;
            $display("FAIL %s done: DoneM=%b StallM=%b BusErrM=%b MemReq=%b want 1 0 0 0", name, DoneM, StallM, BusErrM, MemReq);
        end
        if (!we) begin
            checks++;
            if (LoadDataM !== exp_ld) begin
                failures++;
                $display("FAIL %s load data: got %h want %h", name, LoadDataM, exp_ld);
            end
        end
        cyc; ReqValidM = 1'b0; #1;
        checks++;
        if (DoneM !== 1'b0 || StallM !== 1'b0 || LoadDataM !== 32'h0) begin
            failures++;
            $display("FAIL %s after: DoneM=%b StallM=%b LoadDataM=%h want 0 0 0", name, DoneM, StallM, LoadDataM);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({StallM, DoneM, AdelM, AdesM, BusErrM, MemReq, MemWe} !== 7'b0 ||
            MemAddr !== 32'h0 || MemBE !== 4'h0 || MemWData !== 32'h0 || LoadDataM !== 32'h0) begin
            failures++;
            $display("FAIL reset outputs: Stall=%b Done=%b Req=%b Addr=%h BE=%b want all 0", StallM, DoneM, MemReq, MemAddr, MemBE);
        end
        cyc; cyc;
        rst_n = 1'b1;
        cyc;
    endtask

    task automatic test_store_word;
        run_access("sw", 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0,
                   32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    endtask

    task automatic test_load_byte;
        run_access("lb", 1'b0, 1'b1, 1'b0, 1'b0, 32'h103, 32'h0, 32'h80FF_0000,
                   32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
        run_access("lbu", 1'b0, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80FF_0000,
                   32'h100, 4'b1000, 32'h0, 32'h00000080);
        run_access("lb0", 1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h1234_567F,
                   32'h104, 4'b0001, 32'h0, 32'h0000007F);
    endtask

    task automatic test_half;
        run_access("sh", 1'b1, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0000_1234, 32'h0,
                   32'h100, 4'b1100, 32'h12341234, 32'h0);
        run_access("lh", 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0, 32'h8001_0000,
                   32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
        run_access("lhu", 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 32'h0000_8001,
                   32'h200, 4'b0011, 32'h0, 32'h00008001);
        run_access("sb", 1'b1, 1'b1, 1'b0, 1'b0, 32'h301, 32'hFFFF_FFA5, 32'h0,
                   32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0);
    endtask

    task automatic test_misaligned;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h101, 32'h0);
        #1;
        checks++;
        if (AdelM !== 1'b1 || AdesM !== 1'b0 || StallM !== 1'b0 || MemReq !== 1'b0) begin
            failures++;
            $display("FAIL lw misalign: AdelM=%b AdesM=%b StallM=%b MemReq=%b want 1 0 0 0", AdelM, AdesM, StallM, MemReq);
        end
        cyc;
        checks++;
        if (MemReq !== 1'b0 || AdelM !== 1'b1) begin
            failures++;
            $display("FAIL lw misalign hold: MemReq=%b AdelM=%b want 0 1", MemReq, AdelM);
        end
        set_req(1'b1, 1'b0, 1'b1, 1'b0, 32'h103, 32'h1234);
        #1;
        checks++;
        if (AdesM !== 1'b1 || AdelM !== 1'b0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL sh misalign: AdesM=%b AdelM=%b StallM=%b want 1 0 0", AdesM, AdelM, StallM);
        end
        cyc;
        checks++;
        if (MemReq !== 1'b0) begin
            failures++;
            $display("FAIL sh misalign req: MemReq=%b want 0", MemReq);
        end
        ReqValidM = 1'b0; #1;
        checks++;
        if (AdesM !== 1'b0 || AdelM !== 1'b0) begin
            failures++;
            $display("FAIL misalign clear: AdesM=%b AdelM=%b want 0 0", AdesM, AdelM);
        end
        cyc;
    endtask

    // gnt_cycle = 0 means never granted; cycles 1..7 are REQ with TIMEOUT_CYC=8.
    task automatic test_timeout(input int gnt_cycle, input logic exp_err);
        set_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 32'h55AA55AA);
        for (int i = 1; i <= 7; i++) begin
            cyc; MemGnt = (i == gnt_cycle); #1;
            checks++;
            if (MemReq !== 1'b1 || StallM !== 1'b1 || DoneM !== 1'b0) begin
                failures++;
                $display("FAIL timeout cyc%0d: MemReq=%b StallM=%b DoneM=%b want 1 1 0", i, MemReq, StallM, DoneM);
            end
        end
        cyc; MemGnt = 1'b0; #1;
        checks++;
        if (DoneM !== 1'b1 || BusErrM !== exp_err || MemReq !== 1'b0 || LoadDataM !== 32'h0 || StallM !== 1'b0) begin
            failures++;
            $display("FAIL timeout done: DoneM=%b BusErrM=%b MemReq=%b Load=%h StallM=%b want 1 %b 0 0 0", DoneM, BusErrM, MemReq, LoadDataM, StallM, exp_err);
        end
        cyc; ReqValidM = 1'b0; #1;
        checks++;
        if (MemReq !== 1'b0 || DoneM !== 1'b0 || BusErrM !== 1'b0) begin
            failures++;
            $display("FAIL timeout after: MemReq=%b DoneM=%b BusErrM=%b want 0 0 0", MemReq, DoneM, BusErrM);
        end
    endtask

    task automatic test_reset_mid_access;
        set_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0);
        cyc; MemGnt = 1'b1;
        cyc; MemGnt = 1'b0;
        #1;
        checks++;
        if (StallM !== 1'b1 || MemReq !== 1'b0) begin
            failures++;
            $display("FAIL pre-reset resp: StallM=%b MemReq=%b want 1 0", StallM, MemReq);
        end
        rst_n = 1'b0; ReqValidM = 1'b0; #1;
        checks++;
        if (StallM !== 1'b0 || MemReq !== 1'b0 || DoneM !== 1'b0 || BusErrM !== 1'b0) begin
            failures++;
            $display("FAIL async reset: StallM=%b MemReq=%b DoneM=%b BusErrM=%b want 0 0 0 0", StallM, MemReq, DoneM, BusErrM);
        end
        cyc; rst_n = 1'b1;
        cyc; MemRValid = 1'b1; MemRData = 32'hBAD0BAD0;
        cyc; MemRValid = 1'b0; MemRData = '0; #1;
        checks++;
        if (DoneM !== 1'b0 || StallM !== 1'b0 || LoadDataM !== 32'h0) begin
            failures++;
            $display("FAIL late rvalid: DoneM=%b StallM=%b Load=%h want 0 0 0", DoneM, StallM, LoadDataM);
        end
        cyc;
        run_access("lw post-reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D,
                   32'h204, 4'b1111, 32'h0, 32'hCAFEF00D);
    endtask

    initial begin
        test_reset;
        test_store_word;
        test_load_byte;
        test_half;
        test_misaligned;
        test_timeout(0, 1'b1);
        test_timeout(7, 1'b0);
        test_reset_mid_access;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
